// File: rtl/audio_frame_scheduler.sv
// Purpose: per-frame stereo sample scheduler feeding the I2S DAC serializer (two prioritized sources, mute on starvation).
// Latency: one sample issued per LR-high half, ISSUE_BIT synchronised BCLK rises after LR rise, plus 2 cycles (ARBITRATE, ISSUE).
// Backpressure: sources see a one-cycle ready pulse only in ARBITRATE; the serializer has no ready and must take o_data_valid.
//
// Ports:
//   i_clock, i_reset_n                 system clock, asynchronous active-low reset
//   i_codec_bit_clock/i_codec_lr_clock codec BCLK/LRCLK, asynchronous, synchronised here
//   i_enable                           1 = schedule frames, 0 = finish current step and idle
//   i_src0_*/o_src0_ready              high-priority source (sample pair + valid, ready pulse)
//   i_src1_*/o_src1_ready              low-priority source
//   o_data_left/right, o_data_valid    sample to serializer (held) and one-cycle issue pulse
//   o_src_sel, o_underrun, o_underrun_count  issue source, starvation pulse, saturating count
//
// Build option: AUDIO_SCHED_HOLD_LAST_EN repeats the previous sample on underrun instead of muting.
module audio_frame_scheduler #(
    parameter int DATA_WIDTH = 24,
    parameter int ISSUE_BIT  = 28,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_codec_bit_clock,
    input  logic                  i_codec_lr_clock,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_src0_left,
    input  logic [DATA_WIDTH-1:0] i_src0_right,
    input  logic                  i_src0_valid,
    output logic                  o_src0_ready,
    input  logic [DATA_WIDTH-1:0] i_src1_left,
    input  logic [DATA_WIDTH-1:0] i_src1_right,
    input  logic                  i_src1_valid,
    output logic                  o_src1_ready,
    output logic [DATA_WIDTH-1:0] o_data_left,
    output logic [DATA_WIDTH-1:0] o_data_right,
    output logic                  o_data_valid,
    output logic                  o_src_sel,
    output logic                  o_underrun,
    output logic [CNT_WIDTH-1:0]  o_underrun_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LR_RISE,
        S_COUNT_BITS,
        S_ARBITRATE,
        S_ISSUE
    } state_t;

    localparam logic [5:0] ISSUE_CNT = 6'(ISSUE_BIT);

    state_t state, next_state;

    // Codec clock synchronisers. Edge flags are registered, so an FSM reaction
    // lands four i_clock edges after the pin moves.
    logic bclk_meta, bclk_sync, bclk_dly, bclk_rise;
    logic lr_meta, lr_sync, lr_dly, lr_rise, lr_fall;

    logic [5:0] bit_cnt;
    logic       underrun_pend;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bclk_meta <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_dly  <= 1'b0;
            bclk_rise <= 1'b0;
            lr_meta   <= 1'b0;
            lr_sync   <= 1'b0;
            lr_dly    <= 1'b0;
            lr_rise   <= 1'b0;
            lr_fall   <= 1'b0;
        end else begin
            bclk_meta <= i_codec_bit_clock;
            bclk_sync <= bclk_meta;
            bclk_dly  <= bclk_sync;
            bclk_rise <= bclk_sync & ~bclk_dly;
            lr_meta   <= i_codec_lr_clock;
            lr_sync   <= lr_meta;
            lr_dly    <= lr_sync;
            lr_rise   <= lr_sync & ~lr_dly;
            lr_fall   <= ~lr_sync & lr_dly;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        o_src0_ready = 1'b0;
        o_src1_ready = 1'b0;
        o_data_valid = 1'b0;
        o_underrun   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_enable) next_state = S_WAIT_LR_RISE;
            end
            S_WAIT_LR_RISE: begin
                if (!i_enable)    next_state = S_IDLE;
                else if (lr_rise) next_state = S_COUNT_BITS;
            end
            S_COUNT_BITS: begin
                // A fresh LR rise (short frame) keeps us here with the count
                // restarted; an LR fall means the high half ended too early.
                if (!i_enable)                  next_state = S_IDLE;
                else if (lr_rise)               next_state = S_COUNT_BITS;
                else if (lr_fall)               next_state = S_WAIT_LR_RISE;
                else if (bit_cnt == ISSUE_CNT)  next_state = S_ARBITRATE;
            end
            S_ARBITRATE: begin
                // Always runs through ISSUE so a consumed sample is never lost.
                o_src0_ready = 1'b1;
                o_src1_ready = ~i_src0_valid;
                next_state   = S_ISSUE;
            end
            S_ISSUE: begin
                o_data_valid = 1'b1;
                o_underrun   = underrun_pend;
                next_state   = i_enable ? S_WAIT_LR_RISE : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bit_cnt <= '0;
        end else if ((state == S_WAIT_LR_RISE || state == S_COUNT_BITS) && lr_rise) begin
            bit_cnt <= '0;
        end else if (state == S_COUNT_BITS && bclk_rise && bit_cnt != ISSUE_CNT) begin
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data_left      <= '0;
            o_data_right     <= '0;
            o_src_sel        <= 1'b0;
            underrun_pend    <= 1'b0;
            o_underrun_count <= '0;
        end else begin
            if (state == S_ARBITRATE) begin
                if (i_src0_valid) begin
                    o_data_left   <= i_src0_left;
                    o_data_right  <= i_src0_right;
                    o_src_sel     <= 1'b0;
                    underrun_pend <= 1'b0;
                end else if (i_src1_valid) begin
                    o_data_left   <= i_src1_left;
                    o_data_right  <= i_src1_right;
                    o_src_sel     <= 1'b1;
                    underrun_pend <= 1'b0;
                end else begin
                    underrun_pend <= 1'b1;
`ifdef AUDIO_SCHED_HOLD_LAST_EN
                    // Repeat the previous sample: data and source select untouched.
`else
                    o_data_left   <= '0;
                    o_data_right  <= '0;
                    o_src_sel     <= 1'b0;
`endif
                end
            end
            if (state == S_ISSUE && underrun_pend && o_underrun_count != {CNT_WIDTH{1'b1}}) begin
                o_underrun_count <= o_underrun_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
module tb_audio_frame_scheduler;

    localparam int DW = 24;
    localparam int CW = 4;

    logic          i_clock = 1'b0;
    logic          i_reset_n;
    logic          i_codec_bit_clock;
    logic          i_codec_lr_clock;
    logic          i_enable;
    logic [DW-1:0] i_src0_left, i_src0_right, i_src1_left, i_src1_right;
    logic          i_src0_valid, i_src1_valid;
    logic          o_src0_ready, o_src1_ready;
    logic [DW-1:0] o_data_left, o_data_right;
    logic          o_data_valid, o_src_sel, o_underrun;
    logic [CW-1:0] o_underrun_count;

    audio_frame_scheduler #(.DATA_WIDTH(DW), .ISSUE_BIT(28), .CNT_WIDTH(CW)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_codec_bit_clock(i_codec_bit_clock), .i_codec_lr_clock(i_codec_lr_clock),
        .i_enable(i_enable),
        .i_src0_left(i_src0_left), .i_src0_right(i_src0_right),
        .i_src0_valid(i_src0_valid), .o_src0_ready(o_src0_ready),
        .i_src1_left(i_src1_left), .i_src1_right(i_src1_right),
        .i_src1_valid(i_src1_valid), .o_src1_ready(o_src1_ready),
        .o_data_left(o_data_left), .o_data_right(o_data_right),
        .o_data_valid(o_data_valid), .o_src_sel(o_src_sel),
        .o_underrun(o_underrun), .o_underrun_count(o_underrun_count)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          sel;
        logic          und;
        logic          r1;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_push = 0;
    int   n_rdy = 0;

    // Reference model state: last issued sample and expected underrun count.
    logic [DW-1:0] m_l = '0, m_r = '0;
    logic          m_sel = 1'b0;
    int            m_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // One codec frame: 32 BCLK with LR low, then hi_bits BCLK with LR high.
    // LR changes on the BCLK falling edge as in I2S. drop_at >= 0 clears
    // i_enable at that bit of the high half.
    task automatic do_frame(input int hi_bits, input int drop_at);
        for (int i = 0; i < 32; i++) begin
            i_codec_bit_clock = 1'b0;
            i_codec_lr_clock  = 1'b0;
            #40;
            i_codec_bit_clock = 1'b1;
            #40;
        end
        for (int i = 0; i < hi_bits; i++) begin
            i_codec_bit_clock = 1'b0;
            i_codec_lr_clock  = 1'b1;
            if (i == drop_at) i_enable = 1'b0;
            #40;
            i_codec_bit_clock = 1'b1;
            #40;
        end
    endtask

    task automatic set_src(input logic v0, input logic [DW-1:0] l0, input logic [DW-1:0] r0,
                           input logic v1, input logic [DW-1:0] l1, input logic [DW-1:0] r1);
        i_src0_valid = v0; i_src0_left = l0; i_src0_right = r0;
        i_src1_valid = v1; i_src1_left = l1; i_src1_right = r1;
    endtask

    // Full frame that must produce one issue; expectation pushed before the frame runs.
    task automatic issue_frame(input logic v0, input logic [DW-1:0] l0, input logic [DW-1:0] r0,
                               input logic v1, input logic [DW-1:0] l1, input logic [DW-1:0] r1);
        exp_t e;
        set_src(v0, l0, r0, v1, l1, r1);
        e.r1  = ~v0;
        e.und = 1'b0;
        if (v0) begin
            m_l = l0; m_r = r0; m_sel = 1'b0;
        end else if (v1) begin
            m_l = l1; m_r = r1; m_sel = 1'b1;
        end else begin
            e.und = 1'b1;
`ifndef AUDIO_SCHED_HOLD_LAST_EN
            m_l = '0; m_r = '0; m_sel = 1'b0;
`endif
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        e.l = m_l; e.r = m_r; e.sel = m_sel; e.cnt = CW'(m_cnt);
        exp_q.push_back(e);
        n_push++;
        do_frame(32, -1);
    endtask

    task automatic reset_in_arbitrate();
        set_src(1'b1, 24'h55AA55, 24'hAA55AA, 1'b0, 24'h0, 24'h0);
        fork
            do_frame(32, -1);
            begin : rst_inject
                int k;
                k = 0;
                while (!o_src0_ready && k < 3000) begin
                    @(posedge i_clock);
                    #1;
                    k++;
                end
                check("arbitrate_reached", {63'd0, o_src0_ready}, 64'd1);
                i_reset_n = 1'b0;
                #1;
                check("rst_mid_ready0", {63'd0, o_src0_ready}, 64'd0);
                check("rst_mid_valid", {63'd0, o_data_valid}, 64'd0);
                check("rst_mid_left", {40'd0, o_data_left}, 64'd0);
                check("rst_mid_count", {60'd0, o_underrun_count}, 64'd0);
                m_l = '0; m_r = '0; m_sel = 1'b0; m_cnt = 0;
                #20;
                i_reset_n = 1'b1;
            end
        join
    endtask

    // Monitor: pops an expectation for every issue pulse and checks the
    // preceding ready pulse, pulse width and the following count update.
    int   cyc = 0;
    int   rdy_cyc = -10;
    logic rdy1_seen = 1'b0;
    initial begin
        exp_t it;
        forever begin
            @(negedge i_clock);
            cyc++;
            if (!i_reset_n) continue;
            if (o_src0_ready) begin
                n_rdy++;
                rdy_cyc   = cyc;
                rdy1_seen = o_src1_ready;
            end else if (o_src1_ready) begin
                check("ready1_without_ready0", 64'd1, 64'd0);
            end
            if (o_data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    it = exp_q.pop_front();
                    check("data_left", {40'd0, o_data_left}, {40'd0, it.l});
                    check("data_right", {40'd0, o_data_right}, {40'd0, it.r});
                    check("src_sel", {63'd0, o_src_sel}, {63'd0, it.sel});
                    check("underrun", {63'd0, o_underrun}, {63'd0, it.und});
                    check("valid_latency", 64'(cyc - rdy_cyc), 64'd1);
                    check("ready1", {63'd0, rdy1_seen}, {63'd0, it.r1});
                    @(negedge i_clock);
                    cyc++;
                    check("valid_width", {63'd0, o_data_valid}, 64'd0);
                    check("underrun_count", {60'd0, o_underrun_count}, {60'd0, it.cnt});
                end
            end else if (o_underrun) begin
                check("underrun_without_valid", 64'd1, 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        i_codec_bit_clock = 1'b0;
        i_codec_lr_clock = 1'b0;
        i_enable = 1'b0;
        set_src(1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0);
        #12;
        check("reset_valid", {63'd0, o_data_valid}, 64'd0);
        check("reset_ready0", {63'd0, o_src0_ready}, 64'd0);
        check("reset_left", {40'd0, o_data_left}, 64'd0);
        check("reset_sel", {63'd0, o_src_sel}, 64'd0);
        check("reset_count", {60'd0, o_underrun_count}, 64'd0);
        #20;
        i_reset_n = 1'b1;
        i_enable  = 1'b1;

        // Basic issue from source 0.
        issue_frame(1'b1, 24'h123456, 24'hABCDEF, 1'b0, 24'h0, 24'h0);
        // Priority, then fallback to source 1.
        issue_frame(1'b1, 24'h000001, 24'h000011, 1'b1, 24'h000002, 24'h000022);
        issue_frame(1'b0, 24'h000001, 24'h000011, 1'b1, 24'h000002, 24'h000022);
        // Starved frame.
        issue_frame(1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0);
        // Short frame: LR falls after 10 BCLK rises, nothing may issue.
        set_src(1'b1, 24'h777777, 24'h888888, 1'b0, 24'h0, 24'h0);
        do_frame(10, -1);
        issue_frame(1'b1, 24'h314159, 24'h265358, 1'b0, 24'h0, 24'h0);
        // Disable mid-count, then re-enable for the following frame.
        set_src(1'b1, 24'h666666, 24'h999999, 1'b0, 24'h0, 24'h0);
        do_frame(32, 10);
        i_enable = 1'b1;
        issue_frame(1'b1, 24'hC0FFEE, 24'hBEEF00, 1'b1, 24'h111111, 24'h222222);
        // Reset while in ARBITRATE, then a normal frame.
        reset_in_arbitrate();
        issue_frame(1'b1, 24'h0A0B0C, 24'h0D0E0F, 1'b0, 24'h0, 24'h0);
        // Saturation of the 4-bit underrun counter.
        for (int f = 0; f < 20; f++) begin
            issue_frame(1'b0, 24'h0, 24'h0, 1'b0, 24'h0, 24'h0);
        end
        // Closing LR-low half so the last frame fully drains.
        for (int i = 0; i < 8; i++) begin
            i_codec_bit_clock = 1'b0;
            i_codec_lr_clock  = 1'b0;
            #40;
            i_codec_bit_clock = 1'b1;
            #40;
        end
        repeat (10) @(posedge i_clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("ready_pulse_total", 64'(n_rdy), 64'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
